// File: rtl/riscv_memory_responder.sv
// Memory-side responder for the core's shared memory port: word RAM plus a small
// MMIO block (64-bit cycle counter, console transmit FIFO), answering every request one cycle later.
module riscv_memory_responder #(
  parameter int unsigned RAM_WORDS_LOG2     = 12,
  parameter logic [31:0] MMIO_BASE          = 32'hF000_0000,
  parameter int unsigned CONSOLE_DEPTH_LOG2 = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] memory_address,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [31:0] memory_out,
  output logic [31:0] memory_in,
  output logic        memory_ready,
  output logic [31:0] memory_address_requested,
  output logic [7:0]  console_data,
  output logic        console_valid,
  input  logic        console_ready
);

  localparam int unsigned RAM_WORDS  = 1 << RAM_WORDS_LOG2;
  localparam int unsigned FIFO_DEPTH = 1 << CONSOLE_DEPTH_LOG2;
  localparam int unsigned PTR_W      = CONSOLE_DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    MMIO_COUNT_LO = 2'd0,
    MMIO_COUNT_HI = 2'd1,
    MMIO_CONSOLE  = 2'd2,
    MMIO_CONTROL  = 2'd3
  } mmio_reg_e;

  logic                      req, is_mmio;
  logic [RAM_WORDS_LOG2-1:0] ram_idx;
  mmio_reg_e                 mmio_reg;
  logic                      addr_unused;

  logic [31:0] ram [RAM_WORDS];
  logic [31:0] ram_rdata_q;
  logic [7:0]  fifo [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fifo_count;
  logic             fifo_empty, fifo_full, push_req, push, pop, clear_ovf;
  logic             ovf_q, ovf_d;
  logic [63:0]      cycle_q, cycle_d;
  logic [31:0]      shadow_q, shadow_d;
  logic             ready_q, ready_d;
  logic [31:0]      addr_q, addr_d;
  logic             resp_ram_q, resp_ram_d;
  logic [31:0]      mmio_rdata_q, mmio_rdata_d, mmio_rdata, status;

  assign req         = memory_read | memory_write;
  assign is_mmio     = memory_address >= MMIO_BASE;
  assign ram_idx     = memory_address[RAM_WORDS_LOG2+1:2];
  assign mmio_reg    = mmio_reg_e'(memory_address[3:2]);
  assign addr_unused = ^memory_address[1:0];

  // Pointers carry one extra wrap bit, so their difference is the occupancy.
  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (fifo_count == PTR_W'(FIFO_DEPTH));
  assign status     = {16'h0, 8'(fifo_count), 5'h0, ovf_q, fifo_full, fifo_empty};

  assign pop       = !fifo_empty && console_ready;
  assign push_req  = memory_write && is_mmio && (mmio_reg == MMIO_CONSOLE);
  assign push      = push_req && (!fifo_full || pop);
  assign clear_ovf = memory_write && is_mmio && (mmio_reg == MMIO_CONTROL);

  always_comb begin
    mmio_rdata = 32'h0;
    unique case (mmio_reg)
      MMIO_COUNT_LO: mmio_rdata = cycle_q[31:0];
      MMIO_COUNT_HI: mmio_rdata = shadow_q;
      MMIO_CONSOLE:  mmio_rdata = status;
      MMIO_CONTROL:  mmio_rdata = 32'h0;
    endcase
  end

  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    ready_d      = req;
    addr_d       = addr_q;
    resp_ram_d   = resp_ram_q;
    mmio_rdata_d = mmio_rdata_q;
    shadow_d     = shadow_q;
    cycle_d      = cycle_q + 64'd1;
    ovf_d        = ovf_q;
    wr_ptr_d     = wr_ptr_q + PTR_W'(push);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop);

    if (req) begin
      addr_d     = memory_address;
      resp_ram_d = !is_mmio;
      if (is_mmio) mmio_rdata_d = mmio_rdata;
    end
    // Latching the high word on a low-word read makes a lo/hi read pair coherent.
    if (memory_read && is_mmio && (mmio_reg == MMIO_COUNT_LO)) shadow_d = cycle_q[63:32];

    if (clear_ovf) ovf_d = 1'b0;
    if (push_req && fifo_full && !pop) ovf_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_q      <= 1'b0;
      addr_q       <= 32'h0;
      resp_ram_q   <= 1'b0;
      mmio_rdata_q <= 32'h0;
      shadow_q     <= 32'h0;
      cycle_q      <= 64'h0;
      ovf_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      ready_q      <= ready_d;
      addr_q       <= addr_d;
      resp_ram_q   <= resp_ram_d;
      mmio_rdata_q <= mmio_rdata_d;
      shadow_q     <= shadow_d;
      cycle_q      <= cycle_d;
      ovf_q        <= ovf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // NOTE: storage arrays are deliberately not reset; contents survive reset and map onto RAM macros.
  always_ff @(posedge clock) begin
    if (req && !is_mmio) begin
      ram_rdata_q <= ram[ram_idx];
      if (memory_write) ram[ram_idx] <= memory_out;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo[wr_ptr_q[CONSOLE_DEPTH_LOG2-1:0]] <= memory_out[7:0];
  end

  assign memory_in                = resp_ram_q ? ram_rdata_q : mmio_rdata_q;
  assign memory_ready             = ready_q;
  assign memory_address_requested = addr_q;
  assign console_valid            = !fifo_empty;
  assign console_data             = fifo_empty ? 8'h0 : fifo[rd_ptr_q[CONSOLE_DEPTH_LOG2-1:0]];

endmodule

// File: tb/tb_riscv_memory_responder.sv
// Scoreboard bench for riscv_memory_responder: expected responses and console bytes are
// queued as stimulus is driven and compared when the DUT produces them.
module tb_riscv_memory_responder;

  localparam logic [31:0] MMIO = 32'hF000_0000;
  localparam int          FIFO_DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] memory_address = '0;
  logic        memory_read = 1'b0;
  logic        memory_write = 1'b0;
  logic [31:0] memory_out = '0;
  logic [31:0] memory_in;
  logic        memory_ready;
  logic [31:0] memory_address_requested;
  logic [7:0]  console_data;
  logic        console_valid;
  logic        console_ready = 1'b0;

  riscv_memory_responder dut (
    .clock                    (clock),
    .reset                    (reset),
    .memory_address           (memory_address),
    .memory_read              (memory_read),
    .memory_write             (memory_write),
    .memory_out               (memory_out),
    .memory_in                (memory_in),
    .memory_ready             (memory_ready),
    .memory_address_requested (memory_address_requested),
    .console_data             (console_data),
    .console_valid            (console_valid),
    .console_ready            (console_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          chk;
  } resp_t;

  resp_t       exp_q[$];
  logic [7:0]  cons_q[$];
  logic [31:0] ram_m [int];
  bit          ovf_m;
  int          tests, fails;

  function automatic int widx(input logic [31:0] a);
    return int'(a[13:2]);
  endfunction

  function automatic logic [31:0] status_m();
    logic [7:0] cnt;
    cnt = 8'(cons_q.size());
    return {16'h0, cnt, 5'h0, ovf_m, cnt == 8'(FIFO_DEPTH), cnt == 8'h0};
  endfunction

  // One clock; afterwards any response is popped against the scoreboard.
  task automatic tick();
    resp_t e;
    @(posedge clock);
    #1;
    if (memory_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ready: got ready=1 addr=%h, required ready=0", memory_address_requested);
      end else begin
        e = exp_q.pop_front();
        if (memory_address_requested !== e.addr) begin
          fails++;
          $display("FAIL resp_addr: got %h, required %h", memory_address_requested, e.addr);
        end
        if (e.chk) begin
          tests++;
          if (memory_in !== e.data) begin
            fails++;
            $display("FAIL resp_data @%h: got %h, required %h", e.addr, memory_in, e.data);
          end
        end
      end
    end else if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL missing_ready: no response for addr %h", exp_q[0].addr);
      exp_q.delete();
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_data, input bit chk);
    resp_t e;
    memory_read    = rd;
    memory_write   = wr;
    memory_address = addr;
    memory_out     = wdata;
    e.addr = addr;
    e.data = exp_data;
    e.chk  = chk;
    exp_q.push_back(e);
    tick();
    memory_read  = 1'b0;
    memory_write = 1'b0;
  endtask

  task automatic ram_write(input logic [31:0] addr, input logic [31:0] data, input bit rd_too);
    int i = widx(addr);
    bit known = ram_m.exists(i);
    logic [31:0] old = known ? ram_m[i] : 32'h0;
    ram_m[i] = data;
    drive(rd_too, 1'b1, addr, data, old, known);
  endtask

  task automatic ram_read(input logic [31:0] addr);
    int i = widx(addr);
    bit known = ram_m.exists(i);
    drive(1'b1, 1'b0, addr, 32'h0, known ? ram_m[i] : 32'h0, known);
  endtask

  task automatic console_write(input logic [7:0] b);
    bit popped = console_ready && (cons_q.size() > 0);
    if (popped) void'(cons_q.pop_front());
    if (cons_q.size() < FIFO_DEPTH) cons_q.push_back(b);
    else ovf_m = 1'b1;
    drive(1'b0, 1'b1, MMIO + 32'h8, {24'h0, b}, 32'h0, 1'b0);
  endtask

  task automatic status_read();
    drive(1'b1, 1'b0, MMIO + 32'h8, 32'h0, status_m(), 1'b1);
  endtask

  task automatic drain(input int n);
    console_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      tests++;
      if (cons_q.size() == 0 || console_valid !== 1'b1 || console_data !== cons_q[0]) begin
        fails++;
        $display("FAIL drain[%0d]: got valid=%b data=%h, required valid=1 data=%h",
                 k, console_valid, console_data, cons_q.size() ? cons_q[0] : 8'h0);
      end
      if (cons_q.size() > 0) void'(cons_q.pop_front());
      tick();
    end
    console_ready = 1'b0;
    tests++;
    if (console_valid !== 1'b0 || console_data !== 8'h0) begin
      fails++;
      $display("FAIL drain_empty: got valid=%b data=%h, required valid=0 data=00", console_valid, console_data);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    tests++;
    if (memory_in !== 32'h0 || memory_ready !== 1'b0 || memory_address_requested !== 32'h0 ||
        console_valid !== 1'b0 || console_data !== 8'h0) begin
      fails++;
      $display("FAIL %s: got in=%h rdy=%b addr=%h cv=%b cd=%h, required all zero", tag,
               memory_in, memory_ready, memory_address_requested, console_valid, console_data);
    end
  endtask

  task automatic test_reset();
    #12;
    check_zero_outputs("reset_state");
    @(posedge clock);
    #1;
    reset = 1'b1;
    drive(1'b1, 1'b0, MMIO, 32'h0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, MMIO, 32'h0, 32'h1, 1'b1);
    status_read();
  endtask

  task automatic test_ram();
    ram_write(32'h100, 32'hDEADBEEF, 1'b0);
    ram_read(32'h100);
    ram_read(32'h4100);
    tick();
    tests++;
    if (memory_address_requested !== 32'h4100 || memory_in !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL idle_hold: got addr=%h data=%h, required 00004100 deadbeef",
               memory_address_requested, memory_in);
    end
    ram_write(32'h20, 32'h11111111, 1'b0);
    ram_write(32'h20, 32'h22222222, 1'b0);
    ram_read(32'h20);
    ram_write(32'h20, 32'h33333333, 1'b1);
    ram_read(32'h20);
    ram_write(32'hEFFF_FFFC, 32'h0BAD_F00D, 1'b0);
    ram_read(32'h3FFC);
  endtask

  task automatic test_console_overflow();
    for (int b = 8'h41; b <= 8'h49; b++) begin
      console_write(8'(b));
      if (b == 8'h41) begin
        tests++;
        if (console_valid !== 1'b1 || console_data !== 8'h41) begin
          fails++;
          $display("FAIL first_push_valid: got valid=%b data=%h, required 1 41", console_valid, console_data);
        end
      end
    end
    status_read();
    drain(FIFO_DEPTH);
    status_read();
    ovf_m = 1'b0;
    drive(1'b0, 1'b1, MMIO + 32'hC, 32'hFFFF_FFFF, 32'h0, 1'b0);
    status_read();
    drive(1'b1, 1'b0, MMIO + 32'h2C, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic test_push_pop_full();
    for (int b = 8'h61; b <= 8'h68; b++) console_write(8'(b));
    status_read();
    console_ready = 1'b1;
    tests++;
    if (console_data !== 8'h61) begin
      fails++;
      $display("FAIL full_pop_head: got %h, required 61", console_data);
    end
    console_write(8'h5A);
    console_ready = 1'b0;
    status_read();
    drain(FIFO_DEPTH);
  endtask

  task automatic test_counter_coherent();
    force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.cycle_q;
    drive(1'b1, 1'b0, MMIO, 32'h0, 32'hFFFF_FFFF, 1'b1);
    drive(1'b0, 1'b1, MMIO + 32'h4, 32'h1234_5678, 32'h0, 1'b0);
    drive(1'b1, 1'b0, MMIO + 32'h4, 32'h0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, MMIO + 32'h10, 32'h0, 32'h2, 1'b1);
    drive(1'b1, 1'b0, MMIO + 32'h4, 32'h0, 32'h1, 1'b1);
  endtask

  task automatic test_reset_inflight();
    console_write(8'h77);
    memory_read    = 1'b1;
    memory_address = 32'h100;
    #2;
    reset = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    memory_read = 1'b0;
    cons_q.delete();
    ovf_m = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    tick();
    ram_read(32'h100);
    status_read();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    ovf_m = 1'b0;
    test_reset();
    test_ram();
    test_console_overflow();
    test_push_pop_full();
    test_counter_coherent();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
